// File: rtl/led_pkg.sv
// Shared constants and types for the LED pattern engine and its prescaler.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_SHL = 2'b00,
        MODE_SHR = 2'b01,
        MODE_PP  = 2'b10,
        MODE_BIN = 2'b11
    } led_mode_e;

    // Ping-pong travel direction; DIR_UP moves the lit LED toward the MSB.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Tick period minus one at 50 MHz.
    localparam logic [25:0] CNT_MAX_0S5 = 26'd24_999_999;
    localparam logic [25:0] CNT_MAX_1S  = 26'd49_999_999;

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Control/status bundle between the configuration logic and the LED engine.
interface led_pattern_ctrl_if #(
    parameter int LED_NUM = 8,
    parameter int CNT_W   = 26
);
    logic [1:0]         mode;
    logic [CNT_W-1:0]   step_div;
    logic               pause;
    logic               mode_ld;
    logic [LED_NUM-1:0] led_out;
    logic               step_pulse;
    logic               dir_o;

    modport master (
        output mode, step_div, pause, mode_ld,
        input  led_out, step_pulse, dir_o
    );

    modport slave (
        input  mode, step_div, pause, mode_ld,
        output led_out, step_pulse, dir_o
    );
endinterface

// File: rtl/led_pattern_ctrl_tick_gen.sv
// Programmable prescaler: one-cycle tick every (max+1) active cycles, with
// pause (freeze) and synchronous clear. Shared by other LED/buzzer blocks.
module tick_gen #(
    parameter int               CNT_W       = 26,
    parameter logic [CNT_W-1:0] CNT_MAX_DEF = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] step_div,
    input  logic             pause,
    input  logic             clr,
    output logic             tick
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_max;
    logic             tick_q, tick_d;

    assign cnt_max = (step_div == '0) ? CNT_MAX_DEF : step_div;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (pause) begin
            // Freeze the whole prescaler, including a tick that is already due.
            cnt_d  = cnt_q;
            tick_d = tick_q;
        end else if (cnt_q > cnt_max) begin
            cnt_d  = '0;
        end else if (cnt_q == cnt_max) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q & ~pause;

endmodule

// File: rtl/led_pattern_ctrl.sv
// N-LED pattern engine: shift-left, shift-right, ping-pong and binary count,
// stepped by a shared prescaler tick.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int               LED_NUM     = 8,
    parameter int               CNT_W       = 26,
    parameter logic [CNT_W-1:0] CNT_MAX_DEF = CNT_W'(CNT_MAX_0S5),
    parameter bit               LED_ACT_LOW = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    led_pattern_ctrl_if.slave  bus
);
    localparam logic [LED_NUM-1:0] PAT_INIT = LED_NUM'(1);

    logic [LED_NUM-1:0] pattern_q, pattern_d;
    led_mode_e          mode_q, mode_d;
    dir_e               dir_q, dir_d;
    logic               step_pulse_q, step_pulse_d;
    logic               tick;
    logic [LED_NUM-1:0] led_vec;

    function automatic logic is_onehot(input logic [LED_NUM-1:0] v);
        return (v != '0) && ((v & (v - LED_NUM'(1))) == '0);
    endfunction

    tick_gen #(
        .CNT_W      (CNT_W),
        .CNT_MAX_DEF(CNT_MAX_DEF)
    ) u_tick_gen (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .step_div(bus.step_div),
        .pause   (bus.pause),
        .clr     (bus.mode_ld),
        .tick    (tick)
    );

    always_comb begin
        pattern_d    = pattern_q;
        mode_d       = mode_q;
        dir_d        = dir_q;
        step_pulse_d = 1'b0;
        if (bus.mode_ld) begin
            mode_d    = led_mode_e'(bus.mode);
            pattern_d = PAT_INIT;
            dir_d     = DIR_UP;
        end else if (tick) begin
            step_pulse_d = 1'b1;
            case (mode_q)
                MODE_SHL: pattern_d = is_onehot(pattern_q)
                                    ? {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]}
                                    : PAT_INIT;
                MODE_SHR: pattern_d = is_onehot(pattern_q)
                                    ? {pattern_q[0], pattern_q[LED_NUM-1:1]}
                                    : PAT_INIT;
                MODE_PP: begin
                    if (!is_onehot(pattern_q)) begin
                        pattern_d = PAT_INIT;
                        dir_d     = DIR_UP;
                    end else if (dir_q == DIR_UP) begin
                        pattern_d = pattern_q << 1;
                        if (pattern_d[LED_NUM-1]) dir_d = DIR_DOWN;
                    end else begin
                        pattern_d = pattern_q >> 1;
                        if (pattern_d[0]) dir_d = DIR_UP;
                    end
                end
                MODE_BIN: pattern_d = pattern_q + LED_NUM'(1);
                default:  pattern_d = PAT_INIT;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pattern_q    <= PAT_INIT;
            mode_q       <= MODE_SHL;
            dir_q        <= DIR_UP;
            step_pulse_q <= 1'b0;
        end else begin
            pattern_q    <= pattern_d;
            mode_q       <= mode_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LED_NUM; gi++) begin : g_led
            assign led_vec[gi] = LED_ACT_LOW ? ~pattern_q[gi] : pattern_q[gi];
        end
    endgenerate

    assign bus.led_out    = led_vec;
    assign bus.step_pulse = step_pulse_q;
    assign bus.dir_o      = (dir_q == DIR_DOWN);

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl
Overview: Parametrised LED pattern engine, next generation of the fixed 4-LED running-light block. Drives N LEDs from one shared time base. Supports four selectable modes: shift-left, shift-right, ping-pong and binary count. Step interval, pause and output polarity are runtime/parameter controlled. Sits between board buttons/config logic and the LED pins.

Parameters:
LED_NUM, 8, number of LEDs (2..16)
CNT_W, 26, width of the tick prescaler counter
CNT_MAX_DEF, 26'd24_999_999, tick period minus 1 used when step_div==0 (0.5 s at 50 MHz)
LED_ACT_LOW, 1, 1 = led_out inverted (LED lit on pin low)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous active-low reset
mode  in  2  00 shift-left, 01 shift-right, 10 ping-pong, 11 binary count
step_div  in  CNT_W  tick period minus 1; 0 selects CNT_MAX_DEF
pause  in  1  1 = freeze pattern and prescaler
mode_ld  in  1  one-cycle strobe: sample mode, restart pattern
led_out  out  LED_NUM  LED drive, polarity per LED_ACT_LOW
step_pulse  out  1  one-cycle pulse on each pattern update
dir_o  out  1  current direction, 0 = toward MSB (ping-pong status)

Behaviour:
- Reset (async, sys_rst_n low):
  - cnt = 0, tick = 0, step_pulse = 0, mode_r = 00, dir_o = 0.
  - Pattern = {0..01}, so led_out = ~1 when LED_ACT_LOW=1 (LSB LED lit).
- Prescaler:
  - Effective max = (step_div==0) ? CNT_MAX_DEF : step_div.
  - cnt counts 0..max, then wraps to 0.
  - tick is registered high for one cycle when cnt == max.
  - If step_div changes so that cnt > new max, cnt clears to 0 next cycle; no tick is generated that cycle.
- pause = 1: cnt holds, tick is suppressed, pattern holds. Resume continues from the held cnt.
- mode_ld:
  - Next cycle: mode_r <= mode, pattern <= 0..01, dir_o <= 0, cnt <= 0, tick cleared.
  - mode_ld takes priority over tick and over pause.
- Pattern update on tick (registered; step_pulse asserted in the same cycle the pattern changes):
  - 00 shift-left: rotate left; MSB wraps to bit0.
  - 01 shift-right: rotate right; bit0 wraps to MSB.
  - 10 ping-pong, single hot bit:
    - dir 0: shift left. When the new value has the MSB set, dir <= 1.
    - dir 1: shift right. When the new value has bit0 set, dir <= 0.
    - Endpoints are shown for one tick each. Sequence for LED_NUM=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010...
  - 11 binary count: pattern + 1 modulo 2^LED_NUM; all-ones wraps to 0.
- Illegal or corrupted state recovery: in modes 00/01/10, a pattern that is not one-hot (e.g. all zeros) reloads to 0..01 on the next tick.
- Latency: led_out changes 1 cycle after tick is registered, i.e. (max+2) cycles after reset or restart for the first step, then every max+1 cycles.
- Output:
  - led_out = LED_ACT_LOW ? ~pattern : pattern, taken combinationally from the pattern register. No glitch sources.
  - step_pulse is registered.
- Mode input is ignored except on mode_ld.

Decomposition:
- Package led_pkg:
  - Mode constants MODE_SHL=2'b00, MODE_SHR=2'b01, MODE_PP=2'b10, MODE_BIN=2'b11.
  - Default CNT_MAX constants for 0.5 s / 1 s at 50 MHz.
- Sub-module tick_gen (CNT_W):
  - Prescaler with effective-max select, pause and clear.
  - Outputs a one-cycle tick.
  - Reusable by the breathing-LED and buzzer blocks.

Test Plan:
- Reset with LED_NUM=4, step_div=3, mode_ld with 00 -> led_out=~0001, then ~0010, ~0100, ~1000, ~0001 at 4-cycle spacing; step_pulse accompanies each step.
- mode_ld with 10, step_div=1 -> pattern 0001,0010,0100,1000,0100,0010,0001 at 2-cycle spacing; dir_o goes 1 on 1000 and 0 on 0001.
- mode 11, LED_NUM=4, step_div=0 with CNT_MAX_DEF overridden to 2 -> counts 0001..1111, then 0000, then 0001 every 3 cycles.
- pause held 10 cycles mid-count -> no step_pulse and led_out stable; after release, next step occurs after the remaining cnt cycles only.
- step_div reduced from 9 to 2 while cnt=7 -> cnt clears, no spurious step; next step after 3 cycles; mode_ld asserted together with tick -> pattern=0001, no shift.
- sys_rst_n pulsed low mid-sequence (asynchronously, between edges) -> led_out=~0001 immediately, step_pulse=0, dir_o=0; restart timing matches the first scenario.
